// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier, 8x8 signed -> 16-bit signed product.
// Optional macro BOOTH_SKIP_EN bypasses the ADD state for 00/11 bit pairs.
module booth_seq_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        ready,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  a_q, a_d;
    logic [7:0]  q_q, q_d;
    logic        qm1_q, qm1_d;
    logic [8:0]  mx_q, mx_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        done_q, done_d;

    logic [8:0]  a_add;
    logic [8:0]  a_sub;
    logic [8:0]  a_sh;
    logic [7:0]  q_sh;
    logic        qm1_sh;

    // 9-bit arithmetic keeps a -128 multiplicand exact; wraps modulo 2^9.
    assign a_add  = a_q + mx_q;
    assign a_sub  = a_q - mx_q;
    assign a_sh   = {a_q[8], a_q[8:1]};
    assign q_sh   = {a_q[0], q_q[7:1]};
    assign qm1_sh = q_q[0];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        mx_d      = mx_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = 9'd0;
                    q_d   = multiplier;
                    qm1_d = 1'b0;
                    mx_d  = {multiplicand[7], multiplicand};
                    cnt_d = 3'd0;
`ifdef BOOTH_SKIP_EN
                    state_d = multiplier[0] ? ADD : SHIFT;
`else
                    state_d = ADD;
`endif
                end
            end
            ADD: begin
                case ({q_q[0], qm1_q})
                    2'b10:   a_d = a_sub;
                    2'b01:   a_d = a_add;
                    default: a_d = a_q;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = a_sh;
                q_d   = q_sh;
                qm1_d = qm1_sh;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = {a_sh[7:0], q_sh};
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
`ifdef BOOTH_SKIP_EN
                    state_d = (q_sh[0] ^ qm1_sh) ? ADD : SHIFT;
`else
                    state_d = ADD;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset discards any in-flight operation and clears the held product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 9'd0;
            q_q       <= 8'd0;
            qm1_q     <= 1'b0;
            mx_q      <= 9'd0;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            mx_q      <= mx_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed corners plus random operands
// against an arithmetic reference model.
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        ready;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int passes = 0;

    booth_seq_mult dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_product(input logic [7:0] m, input logic [7:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[15:0];
    endfunction

    // Edges from acceptance to completion: fixed 16, or 8 plus one per
    // bit pair (Q[i],Q[i-1]) that differs when skipping is enabled.
    function automatic int ref_latency(input logic [7:0] q);
`ifdef BOOTH_SKIP_EN
        int k;
        logic prev;
        k = 0;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (q[i] != prev) k++;
            prev = q[i];
        end
        return 8 + k;
`else
        return 16;
`endif
    endfunction

    // Drives one operation from IDLE; returns latency in edges after the
    // accept edge (-1 on timeout) and the product seen with done.
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          output logic [15:0] p, output int lat);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(posedge clk); #1;
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        lat = -1;
        p = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                p = product;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = 8'd0;
        multiplier = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready, done, product} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL reset_state: ready=%b done=%b product=%h, required 1 0 0000", ready, done, product);
        else passes++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [7:0]  ms [6] = '{8'd5, 8'h80, 8'd127, 8'hFF, 8'h80, 8'd3};
        logic [7:0]  qs [6] = '{8'd3, 8'h80, 8'h80, 8'd1, 8'd0, 8'd5};
        logic [15:0] p;
        logic [15:0] exp_p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(ms[i], qs[i], p, lat);
            exp_p = ref_product(ms[i], qs[i]);
            checks++;
            if (p !== exp_p || lat != ref_latency(qs[i]))
                $display("FAIL directed_%0d: product=%h lat=%0d, required %h lat=%0d", i, p, lat, exp_p, ref_latency(qs[i]));
            else passes++;
            checks++;
            if (ready !== 1'b1)
                $display("FAIL ready_at_done_%0d: ready=%b, required 1", i, ready);
            else passes++;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || product !== exp_p)
                $display("FAIL done_pulse_%0d: done=%b product=%h, required 0 %h", i, done, product, exp_p);
            else passes++;
        end
    endtask

    task automatic test_ignore_start;
        logic [15:0] p;
        logic [15:0] exp_p;
        int lat;
        exp_p = ref_product(8'd23, 8'hE9);
        start = 1'b1;
        multiplicand = 8'd23;
        multiplier = 8'hE9;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        p = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 4) begin
                start = 1'b1;
                multiplicand = 8'h7F;
                multiplier = 8'h7F;
            end else if (i == 5) begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                p = product;
                break;
            end
        end
        checks++;
        if (p !== exp_p || lat != ref_latency(8'hE9))
            $display("FAIL ignore_start: product=%h lat=%0d, required %h lat=%0d", p, lat, exp_p, ref_latency(8'hE9));
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] m;
        logic [7:0] q;
        int lat;
        int exp_lat;
        m = 8'd77;
        q = 8'hA5;
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(posedge clk); #1;
        exp_lat = ref_latency(q);
        for (int op = 0; op < 4; op++) begin
            lat = -1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk); #1;
                if (done) begin
                    lat = i;
                    break;
                end
            end
            checks++;
            if (lat != exp_lat || product !== ref_product(m, q))
                $display("FAIL back_to_back_%0d: product=%h lat=%0d, required %h lat=%0d", op, product, lat, ref_product(m, q), exp_lat);
            else passes++;
            m = $urandom;
            q = $urandom;
            multiplicand = m;
            multiplier = q;
            exp_lat = 1 + ref_latency(q);
        end
        start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [15:0] p;
        int lat;
        int seen;
        run_op(8'd9, 8'd9, p, lat);
        start = 1'b1;
        multiplicand = 8'd100;
        multiplier = 8'hC3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({ready, done, product} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL reset_mid: ready=%b done=%b product=%h, required 1 0 0000", ready, done, product);
        else passes++;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0)
            $display("FAIL reset_no_done: done pulses=%0d, required 0", seen);
        else passes++;
    endtask

    task automatic test_random;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 200; i++) begin
            m = $urandom;
            q = $urandom;
            run_op(m, q, p, lat);
            checks++;
            if (p !== ref_product(m, q) || lat != ref_latency(q))
                $display("FAIL random_%0d: %h*%h product=%h lat=%0d, required %h lat=%0d",
                         i, m, q, p, lat, ref_product(m, q), ref_latency(q));
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
